// File: rtl/lcd_pkg.sv
// Shared constants for the LCD pixel FIFO: entry layout, pixel width and FSM state encoding.
package lcd_pkg;

  // RGB565 pixel width
  localparam int unsigned PIX_W = 16;

  // Entry layout: {sof, pix, data[15:0]}
  localparam int unsigned ENTRY_W        = PIX_W + 2;
  localparam int unsigned ENTRY_DATA_LSB = 0;
  localparam int unsigned ENTRY_PIX_BIT  = PIX_W;
  localparam int unsigned ENTRY_SOF_BIT  = PIX_W + 1;

  // Output FSM state encoding
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCursor  = 3'd1;
  localparam logic [2:0] StCurWait = 3'd2;
  localparam logic [2:0] StPixel   = 3'd3;
  localparam logic [2:0] StPixWait = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO on inferred block RAM with a registered read port.
// rdata always presents the head entry whenever the FIFO is not empty: the read
// address is the next-cycle read pointer, and a write to that same address is
// forwarded (write-first) so a push into an empty FIFO is visible one cycle later.
module sync_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 512
) (
  input  logic                       clk_i,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_addr;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] rdata_q;
  logic             push_ok, pop_ok;

  assign full  = (level_q == FullLevel);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = rdata_q;

  // A push into a full FIFO is only accepted when a pop frees a slot that cycle
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    rd_addr = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Storage write port (no reset so it maps onto block RAM)
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Registered read of the next head, forwarding a same-address write
  always_ff @(posedge clk_i) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else if (push_ok && (wr_ptr_q == rd_addr)) begin
      rdata_q <= wdata;
    end else begin
      rdata_q <= mem[rd_addr];
    end
  end

  // Pointers wrap naturally modulo DEPTH; level tracks push/pop balance
  always_ff @(posedge clk_i) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/lcd_pixel_fifo.sv
// Pixel/cursor FIFO between the TIA pixel stream and the ili9341 driver.
// Entries are {sof, pix, data}; the output FSM turns each entry into a cursor
// pulse and/or a pixel pulse, honouring a guard time and the driver busy flag.
// DEPTH must be a power of two and at least 4.
module lcd_pixel_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned GUARD = 2
) (
  input  logic                     clk_i,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [PIX_W-1:0]         in_data,
  input  logic                     in_sof,
  output logic                     in_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     lcd_reset_cursor,
  output logic [PIX_W-1:0]         lcd_pix_data,
  output logic                     lcd_pix_clk,
  input  logic                     lcd_busy
);

  localparam int unsigned CW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  logic               push_req, pop, drop, full, empty;
  logic [ENTRY_W-1:0] push_entry, head, hold_q;
  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PIX_W-1:0]   pix_data_q;
  logic               overflow_q;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .resetn (resetn),
    .push   (push_req),
    .wdata  (push_entry),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  // Build the entry; data is zeroed for cursor-only entries
  always_comb begin
    push_entry                                = '0;
    push_entry[ENTRY_SOF_BIT]                 = in_sof;
    push_entry[ENTRY_PIX_BIT]                 = in_valid;
    if (in_valid) begin
      push_entry[ENTRY_DATA_LSB +: PIX_W]     = in_data;
    end
    push_req = in_valid | in_sof;
    pop      = (state_q == StIdle) && !empty && !lcd_busy;
    drop     = push_req && full && !pop;
  end

  // Output FSM next state and guard counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (pop) state_d = head[ENTRY_SOF_BIT] ? StCursor : StPixel;
      end
      StCursor: begin
        state_d = StCurWait;
        cnt_d   = CW'(GUARD);
      end
      StCurWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!lcd_busy) begin
          state_d = hold_q[ENTRY_PIX_BIT] ? StPixel : StIdle;
        end
      end
      StPixel: begin
        state_d = StPixWait;
        cnt_d   = CW'(GUARD);
      end
      StPixWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!lcd_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, guard counter and holding register
  always_ff @(posedge clk_i) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) hold_q <= head;
    end
  end

  // Last strobed pixel, so lcd_pix_data holds between strobes
  always_ff @(posedge clk_i) begin
    if (!resetn) begin
      pix_data_q <= '0;
    end else if (state_q == StPixel) begin
      pix_data_q <= hold_q[ENTRY_DATA_LSB +: PIX_W];
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins
  always_ff @(posedge clk_i) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  // hold_q sof is always set in StCursor; the AND keeps the held entry self-describing
  assign lcd_reset_cursor = (state_q == StCursor) && hold_q[ENTRY_SOF_BIT];
  assign lcd_pix_clk      = (state_q == StPixel);
  assign lcd_pix_data     = lcd_pix_clk ? hold_q[ENTRY_DATA_LSB +: PIX_W] : pix_data_q;
  assign in_full          = full;
  assign overflow         = overflow_q;

endmodule
